// File: rtl/decode_if.sv
// Decode-stage bus: fetch offer, register-file read port, writeback/flush and execute handoff.
// master = surrounding pipeline, slave = decode_stage.
interface decode_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  data_addr1;
    logic [4:0]  data_addr2;
    logic [31:0] rf_data1;
    logic [31:0] rf_data2;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic        ex_we;

    modport master (
        output instr_valid, instr, rf_data1, rf_data2, wb_valid, wb_addr, flush, ex_ready,
        input  instr_ready, data_addr1, data_addr2, ex_valid, ex_rd, ex_opcode, ex_funct3,
               ex_funct7, ex_imm, ex_rs1_val, ex_rs2_val, ex_we
    );

    modport slave (
        input  instr_valid, instr, rf_data1, rf_data2, wb_valid, wb_addr, flush, ex_ready,
        output instr_ready, data_addr1, data_addr2, ex_valid, ex_rd, ex_opcode, ex_funct3,
               ex_funct7, ex_imm, ex_rs1_val, ex_rs2_val, ex_we
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate decode, pending-write scoreboard, registered execute handoff.
// Define DECODE_WB_BYPASS_EN to let a dependent instruction issue in its writeback cycle.
module decode_stage (
    input logic     clk,
    input logic     reset,
    decode_if.slave bus
);
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;

    logic [31:0] pending_q, pending_d, pending_eff;
    logic        ex_valid_q, ex_valid_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic [6:0]  ex_opcode_q, ex_opcode_d;
    logic [2:0]  ex_funct3_q, ex_funct3_d;
    logic [6:0]  ex_funct7_q, ex_funct7_d;
    logic [31:0] ex_imm_q, ex_imm_d;
    logic [31:0] ex_rs1_val_q, ex_rs1_val_d;
    logic [31:0] ex_rs2_val_q, ex_rs2_val_d;
    logic        ex_we_q, ex_we_d;

    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_used, rs2_used, we_dec;
    logic [31:0] imm_dec;
    logic        hazard, ready, accept;

    assign ins    = bus.instr;
    assign opcode = ins[6:0];
    assign rd     = ins[11:7];
    assign rs1    = ins[19:15];
    assign rs2    = ins[24:20];

    assign bus.data_addr1 = rs1;
    assign bus.data_addr2 = rs2;

    always_comb begin
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        we_dec   = 1'b0;
        imm_dec  = '0;
        case (opcode)
            OpLui, OpAuipc: begin
                rs1_used = 1'b0;
                we_dec   = 1'b1;
                imm_dec  = {ins[31:12], 12'b0};
            end
            OpJal: begin
                rs1_used = 1'b0;
                we_dec   = 1'b1;
                imm_dec  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            OpJalr, OpLoad, OpImm: begin
                we_dec  = 1'b1;
                imm_dec = {{21{ins[31]}}, ins[30:20]};
            end
            OpOp: begin
                rs2_used = 1'b1;
                we_dec   = 1'b1;
            end
            OpStore: begin
                rs2_used = 1'b1;
                imm_dec  = {{21{ins[31]}}, ins[30:25], ins[11:7]};
            end
            OpBranch: begin
                rs2_used = 1'b1;
                imm_dec  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            default: ;
        endcase
        if (rd == 5'd0) we_dec = 1'b0;
    end

`ifdef DECODE_WB_BYPASS_EN
    // Retiring write is visible this cycle, so its pending bit no longer blocks issue.
    always_comb begin
        pending_eff = pending_q;
        if (bus.wb_valid) pending_eff[bus.wb_addr] = 1'b0;
    end
`else
    assign pending_eff = pending_q;
`endif

    assign hazard = (rs1_used && pending_eff[rs1]) || (rs2_used && pending_eff[rs2]);
    assign ready  = !hazard && (!ex_valid_q || bus.ex_ready) && !bus.flush;
    assign accept = bus.instr_valid && ready;
    assign bus.instr_ready = ready;

    always_comb begin
        pending_d    = pending_q;
        ex_valid_d   = ex_valid_q;
        ex_rd_d      = ex_rd_q;
        ex_opcode_d  = ex_opcode_q;
        ex_funct3_d  = ex_funct3_q;
        ex_funct7_d  = ex_funct7_q;
        ex_imm_d     = ex_imm_q;
        ex_rs1_val_d = ex_rs1_val_q;
        ex_rs2_val_d = ex_rs2_val_q;
        ex_we_d      = ex_we_q;

        if (bus.wb_valid && bus.wb_addr != 5'd0) pending_d[bus.wb_addr] = 1'b0;
        if (bus.flush && ex_valid_q && ex_we_q) pending_d[ex_rd_q] = 1'b0;
        // Applied last so a same-edge set beats any clear of that bit.
        if (accept && we_dec) pending_d[rd] = 1'b1;
        pending_d[0] = 1'b0;

        if (bus.flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d   = 1'b1;
            ex_rd_d      = rd;
            ex_opcode_d  = opcode;
            ex_funct3_d  = ins[14:12];
            ex_funct7_d  = ins[31:25];
            ex_imm_d     = imm_dec;
            ex_rs1_val_d = bus.rf_data1;
            ex_rs2_val_d = bus.rf_data2;
            ex_we_d      = we_dec;
        end else if (bus.ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q    <= '0;
            ex_valid_q   <= 1'b0;
            ex_rd_q      <= '0;
            ex_opcode_q  <= '0;
            ex_funct3_q  <= '0;
            ex_funct7_q  <= '0;
            ex_imm_q     <= '0;
            ex_rs1_val_q <= '0;
            ex_rs2_val_q <= '0;
            ex_we_q      <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            ex_valid_q   <= ex_valid_d;
            ex_rd_q      <= ex_rd_d;
            ex_opcode_q  <= ex_opcode_d;
            ex_funct3_q  <= ex_funct3_d;
            ex_funct7_q  <= ex_funct7_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs1_val_q <= ex_rs1_val_d;
            ex_rs2_val_q <= ex_rs2_val_d;
            ex_we_q      <= ex_we_d;
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_opcode  = ex_opcode_q;
    assign bus.ex_funct3  = ex_funct3_q;
    assign bus.ex_funct7  = ex_funct7_q;
    assign bus.ex_imm     = ex_imm_q;
    assign bus.ex_rs1_val = ex_rs1_val_q;
    assign bus.ex_rs2_val = ex_rs2_val_q;
    assign bus.ex_we      = ex_we_q;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios then random traffic against a
// reference model of the scoreboard and execute handoff.
module tb_decode_stage;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011, OPIMM = 7'b0010011, OP = 7'b0110011;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    decode_if bif ();
    decode_stage dut (.clk(clk), .reset(reset), .bus(bif));

    logic [31:0] rf_mem [32];
    assign bif.rf_data1 = rf_mem[bif.data_addr1];
    assign bif.rf_data2 = rf_mem[bif.data_addr2];

    int checks = 0;
    int errors = 0;
    logic last_ready;

    // Reference model state
    logic [31:0] pend;
    logic        m_valid, m_we;
    logic [4:0]  m_rd;
    logic [6:0]  m_op, m_f7;
    logic [2:0]  m_f3;
    logic [31:0] m_imm, m_rs1v, m_rs2v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic writes_rd(input logic [31:0] i);
        return (i[6:0] inside {OP, OPIMM, LOAD, LUI, AUIPC, JAL, JALR}) && (i[11:7] != 5'd0);
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] i);
        int s;
        s = $signed(i);
        case (i[6:0])
            OPIMM, LOAD, JALR: return 32'(s >>> 20);
            STORE:  return 32'(((s >>> 25) <<< 5) | int'(i[11:7]));
            BRANCH: return 32'(((s >>> 31) <<< 12) | (int'(i[7]) << 11) |
                               (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1));
            LUI, AUIPC: return i & 32'hFFFF_F000;
            JAL:    return 32'(((s >>> 31) <<< 20) | (int'(i[19:12]) << 12) |
                               (int'(i[20]) << 11) | (int'(i[30:21]) << 1));
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic blocked(input logic [31:0] i, input logic wv, input logic [4:0] wa);
        logic [31:0] p;
        logic u1, u2;
        p = pend;
`ifdef DECODE_WB_BYPASS_EN
        if (wv) p[wa] = 1'b0;
`endif
        u1 = !(i[6:0] inside {LUI, AUIPC, JAL});
        u2 = i[6:0] inside {BRANCH, STORE, OP};
        return (u1 && p[i[19:15]]) || (u2 && p[i[24:20]]);
    endfunction

    task automatic model_clear();
        pend = '0; m_valid = 0; m_we = 0; m_rd = '0; m_op = '0; m_f7 = '0; m_f3 = '0;
        m_imm = '0; m_rs1v = '0; m_rs2v = '0;
    endtask

    task automatic chk_ex();
        chk("ex_valid", bif.ex_valid, m_valid);
        chk("ex_rd", bif.ex_rd, m_rd);
        chk("ex_opcode", bif.ex_opcode, m_op);
        chk("ex_funct3", bif.ex_funct3, m_f3);
        chk("ex_funct7", bif.ex_funct7, m_f7);
        chk("ex_imm", bif.ex_imm, m_imm);
        chk("ex_rs1_val", bif.ex_rs1_val, m_rs1v);
        chk("ex_rs2_val", bif.ex_rs2_val, m_rs2v);
        chk("ex_we", bif.ex_we, m_we);
    endtask

    task automatic step(input logic iv, input logic [31:0] ins, input logic rdy,
                        input logic wv, input logic [4:0] wa, input logic fl);
        logic exp_ready;
        @(negedge clk);
        bif.instr_valid = iv; bif.instr = ins; bif.ex_ready = rdy;
        bif.wb_valid = wv; bif.wb_addr = wa; bif.flush = fl;
        #1;
        exp_ready = !blocked(ins, wv, wa) && (!m_valid || rdy) && !fl;
        chk("instr_ready", bif.instr_ready, exp_ready);
        chk("data_addr1", bif.data_addr1, ins[19:15]);
        chk("data_addr2", bif.data_addr2, ins[24:20]);
        last_ready = bif.instr_ready;
        @(posedge clk);
        if (fl && m_valid && m_we) pend[m_rd] = 1'b0;
        if (wv && wa != 5'd0) pend[wa] = 1'b0;
        if (iv && exp_ready && writes_rd(ins)) pend[ins[11:7]] = 1'b1;
        if (fl) m_valid = 0;
        else if (iv && exp_ready) begin
            m_valid = 1; m_rd = ins[11:7]; m_op = ins[6:0]; m_f3 = ins[14:12];
            m_f7 = ins[31:25]; m_imm = exp_imm(ins); m_we = writes_rd(ins);
            m_rs1v = rf_mem[ins[19:15]]; m_rs2v = rf_mem[ins[24:20]];
        end else if (rdy) m_valid = 0;
        #1;
        chk_ex();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        model_clear();
        chk_ex();
        #2 reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 10))
            0: i[6:0] = LUI;    1: i[6:0] = AUIPC; 2: i[6:0] = JAL;   3: i[6:0] = JALR;
            4: i[6:0] = BRANCH; 5: i[6:0] = LOAD;  6: i[6:0] = STORE; 7: i[6:0] = OPIMM;
            8: i[6:0] = OP;     9: i[6:0] = 7'b1110011;
            default: i[6:0] = 7'b0001111;
        endcase
        i[11:7] = 5'($urandom_range(0, 7));
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
        return i;
    endfunction

    initial begin
        for (int r = 0; r < 32; r++) rf_mem[r] = $urandom;
        bif.instr_valid = 0; bif.instr = '0; bif.ex_ready = 0;
        bif.wb_valid = 0; bif.wb_addr = '0; bif.flush = 0;
        model_clear();
        #1;
        chk_ex();
        #1 reset = 1'b0;

        // ADDI x4,x0,-1
        step(1, 32'hFFF00213, 1, 0, 5'd0, 0);
        chk("r031_valid", bif.ex_valid, 1);
        chk("r031_rd", bif.ex_rd, 4);
        chk("r031_imm", bif.ex_imm, 32'hFFFF_FFFF);
        chk("r031_we", bif.ex_we, 1);
        // ADD x5,x4,x4 waits on x4
        step(1, 32'h004202B3, 1, 0, 5'd0, 0);
        chk("r032_stall_a", last_ready, 0);
        step(1, 32'h004202B3, 1, 0, 5'd0, 0);
        chk("r032_stall_b", last_ready, 0);
        step(1, 32'h004202B3, 1, 1, 5'd4, 0);
`ifdef DECODE_WB_BYPASS_EN
        chk("r032_wb_cycle", last_ready, 1);
`else
        chk("r032_wb_cycle", last_ready, 0);
        step(1, 32'h004202B3, 1, 0, 5'd0, 0);
        chk("r032_after_wb", last_ready, 1);
`endif
        chk("r032_rd", bif.ex_rd, 5);

        // ADDI x6 accepted, then execute back-pressure for 3 cycles
        step(1, 32'h00500313, 1, 0, 5'd0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 32'h00100493, 0, 0, 5'd0, 0);
            chk("r033_stall", last_ready, 0);
            chk("r033_rd_hold", bif.ex_rd, 6);
        end
        step(1, 32'h00100493, 1, 0, 5'd0, 0);
        chk("r033_release", last_ready, 1);
        chk("r033_rd_new", bif.ex_rd, 9);

        // ADDI x0,x0,1 then ADD x1,x0,x0
        step(1, 32'h00100013, 1, 0, 5'd0, 0);
        chk("r034_we", bif.ex_we, 0);
        step(1, 32'h000000B3, 1, 0, 5'd0, 0);
        chk("r034_x0_free", last_ready, 1);

        // ADDI x7 then flush it; ADD x8,x7,x7 must issue at once
        step(1, 32'h00300393, 1, 0, 5'd0, 0);
        step(0, 32'h0, 0, 0, 5'd0, 1);
        chk("r035_valid", bif.ex_valid, 0);
        step(1, 32'h00738433, 1, 0, 5'd0, 0);
        chk("r035_x7_clear", last_ready, 1);

        // ADD x10,x8,x0 stalls on x8; reset clears the scoreboard
        step(1, 32'h00040533, 1, 0, 5'd0, 0);
        chk("r036_stall", last_ready, 0);
        pulse_reset();
        chk("r036_valid", bif.ex_valid, 0);
        step(1, 32'h00040533, 1, 0, 5'd0, 0);
        chk("r036_accept", last_ready, 1);

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) < 8, rand_instr(), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)),
                 $urandom_range(0, 19) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
